pipe_reg: RTL

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_reg.sv | 97 +++++++++
 1 files changed

// File: rtl/pipe_reg.sv
// Bubble-collapsing valid/ready register pipeline of DEPTH stages.
// An empty stage pulls a beat forward even when the stages ahead of it are stalled.
module pipe_reg #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CNT_W-1:0] count_q;

  // load[k]: stage k takes a new beat (or goes empty) at the next edge.
  // take[k]: a beat is actually arriving at stage k.
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] take;
  logic [DEPTH-1:0] valid_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             chain;

  // NOTE: combinational logic uses blocking '=' with a default assigned first so
  // no latch is inferred; the sequential block below uses non-blocking '<=' only.
  always_comb begin
    chain = out_ready_i;
    load  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      load[k] = !valid_q[k] || chain;
      chain   = load[k];
    end
  end

  // Reset gates ready so nothing is accepted while the pipe is being cleared.
  assign in_ready_o = load[0] && !flush_i && reset_n;

  always_comb begin
    take    = '0;
    take[0] = in_valid_i && in_ready_o;
    for (int k = 1; k < DEPTH; k++) begin
      take[k] = valid_q[k-1];
    end
  end

  always_comb begin
    valid_nxt = valid_q;
    count_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush_i) begin
        valid_nxt[k] = 1'b0;
      end else if (load[k]) begin
        valid_nxt[k] = take[k];
      end
      count_nxt = count_nxt + CNT_W'(valid_nxt[k]);
    end
  end

  // NOTE: the data array is reset as well as the valid bits, so the output bus
  // shows RST_VAL rather than X after reset; this costs a reset input per flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RST_VAL;
      end
    end else begin
      valid_q <= valid_nxt;
      count_q <= count_nxt;
      // Data only moves with a real beat; flush and bubbles leave registers as they are.
      if (!flush_i && load[0] && take[0]) begin
        data_q[0] <= in_data_i;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (!flush_i && load[k] && take[k]) begin
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];
  assign count_o     = count_q;

endmodule
